// File: rtl/writeback_queue.sv
// Writeback queue: buffers condition-passed results in a small FIFO and drains
// them into a 32-bit register file whenever the write port is free.
module writeback_queue #(
    parameter  int DEPTH = 4,
    parameter  int NREGS = 32,
    localparam int AW    = $clog2(NREGS),
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [AW-1:0] in_dest,
    input  logic [31:0]   in_data,
    input  logic          in_cond_pass,
    input  logic          wr_stall,
    input  logic [AW-1:0] rd_addr0,
    input  logic [AW-1:0] rd_addr1,
    output logic [31:0]   rd_data0,
    output logic [31:0]   rd_data1,
    output logic          rd_pending0,
    output logic          rd_pending1,
    output logic [CW-1:0] count
);

    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW:0]   NREGS_W    = (AW + 1)'(NREGS);

    logic [AW-1:0] dest_q  [DEPTH];
    logic [31:0]   data_q  [DEPTH];
    logic [DEPTH-1:0] valid_q;
    logic [31:0]   regs_q  [NREGS];

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic push, pop;
    logic [DEPTH-1:0] match0, match1;

    // Indices past NREGS can only occur when NREGS is not a power of two.
    function automatic logic in_range(input logic [AW-1:0] a);
        return {1'b0, a} < NREGS_W;
    endfunction

    assign in_ready = (count_q < FULL_COUNT);
    assign push     = in_valid && in_ready && in_cond_pass;
    assign pop      = (count_q != '0) && !wr_stall;
    assign count    = count_q;

    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q + CW'(push) - CW'(pop);
        if (pop)  head_d = head_q + PW'(1);
        if (push) tail_d = tail_q + PW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            // Head and tail only coincide when empty or full, so the valid
            // clear and set below never target the same slot in one edge.
            if (pop) begin
                valid_q[head_q] <= 1'b0;
                if (in_range(dest_q[head_q]))
                    regs_q[dest_q[head_q]] <= data_q[head_q];
            end
            if (push) valid_q[tail_q] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            dest_q[tail_q] <= in_dest;
            data_q[tail_q] <= in_data;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_match
            assign match0[gi] = valid_q[gi] && (dest_q[gi] == rd_addr0);
            assign match1[gi] = valid_q[gi] && (dest_q[gi] == rd_addr1);
        end
    endgenerate

    assign rd_pending0 = |match0;
    assign rd_pending1 = |match1;
    assign rd_data0    = in_range(rd_addr0) ? regs_q[rd_addr0] : 32'h0;
    assign rd_data1    = in_range(rd_addr1) ? regs_q[rd_addr1] : 32'h0;

endmodule

// File: tb/tb_writeback_queue.sv
// Directed bench for writeback_queue (DEPTH=4, NREGS=32) with hand-computed
// expected values checked by immediate assertions.
module tb_writeback_queue;

    localparam int DEPTH = 4;
    localparam int NREGS = 32;
    localparam int AW    = 5;
    localparam int CW    = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] in_dest;
    logic [31:0]   in_data;
    logic          in_cond_pass;
    logic          wr_stall;
    logic [AW-1:0] rd_addr0, rd_addr1;
    logic [31:0]   rd_data0, rd_data1;
    logic          rd_pending0, rd_pending1;
    logic [CW-1:0] count;

    int errors = 0;
    int checks = 0;

    writeback_queue #(.DEPTH(DEPTH), .NREGS(NREGS)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_dest(in_dest), .in_data(in_data), .in_cond_pass(in_cond_pass),
        .wr_stall(wr_stall),
        .rd_addr0(rd_addr0), .rd_addr1(rd_addr1),
        .rd_data0(rd_data0), .rd_data1(rd_data1),
        .rd_pending0(rd_pending0), .rd_pending1(rd_pending1),
        .count(count)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 ns after it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic peek(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
        rd_addr0 = a0;
        rd_addr1 = a1;
        #1;
    endtask

    task automatic offer(input logic [AW-1:0] d, input logic [31:0] v, input logic p);
        in_valid     = 1'b1;
        in_dest      = d;
        in_data      = v;
        in_cond_pass = p;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0;
        in_cond_pass = 1'b0; wr_stall = 1'b0; rd_addr0 = '0; rd_addr1 = '0;
        step(); step();
        rst = 1'b0;
        peek(5'd5, 5'd3);
        check("reset_count",    32'(count), 32'd0);
        check("reset_ready",    32'(in_ready), 32'd1);
        check("reset_pending0", 32'(rd_pending0), 32'd0);
        check("reset_pending1", 32'(rd_pending1), 32'd0);
        check("reset_rd0",      rd_data0, 32'h0);
        check("reset_rd1",      rd_data1, 32'h0);

        // Single push, then drain one edge later
        offer(5'd5, 32'hDEADBEEF, 1'b1);
        step();
        in_valid = 1'b0;
        check("push1_count",   32'(count), 32'd1);
        check("push1_pending", 32'(rd_pending0), 32'd1);
        check("push1_no_pass", rd_data0, 32'h0);
        step();
        check("drain1_rd",      rd_data0, 32'hDEADBEEF);
        check("drain1_count",   32'(count), 32'd0);
        check("drain1_pending", 32'(rd_pending0), 32'd0);

        // Condition-failed transfer is discarded
        offer(5'd3, 32'h11, 1'b0);
        check("discard_ready", 32'(in_ready), 32'd1);
        step();
        in_valid = 1'b0;
        check("discard_count",   32'(count), 32'd0);
        check("discard_pending", 32'(rd_pending1), 32'd0);
        step();
        check("discard_reg3", rd_data1, 32'h0);

        // Fill under stall, refuse a fifth, then drain in order
        wr_stall = 1'b1;
        for (int i = 0; i < 4; i++) begin
            offer(5'(10 + i), 32'hA0 + 32'(i), 1'b1);
            step();
        end
        in_valid = 1'b0;
        check("full_count", 32'(count), 32'd4);
        check("full_ready", 32'(in_ready), 32'd0);
        offer(5'd14, 32'hBAD, 1'b1);
        step();
        in_valid = 1'b0;
        peek(5'd10, 5'd14);
        check("full_refuse_count",   32'(count), 32'd4);
        check("full_refuse_pending", 32'(rd_pending1), 32'd0);
        check("stalled_reg10",       rd_data0, 32'h0);
        wr_stall = 1'b0;
        step();
        check("drain_q0_rd",    rd_data0, 32'hA0);
        check("drain_q0_count", 32'(count), 32'd3);
        check("drain_q0_ready", 32'(in_ready), 32'd1);
        for (int i = 1; i < 4; i++) begin
            peek(5'(10 + i), 5'd14);
            check("drain_order_before", rd_data0, 32'h0);
            step();
            check("drain_order_rd",    rd_data0, 32'hA0 + 32'(i));
            check("drain_order_count", 32'(count), 32'(3 - i));
        end
        check("refused_reg14", rd_data1, 32'h0);

        // Repeated writes to one register: last value wins
        peek(5'd7, 5'd0);
        offer(5'd7, 32'h1, 1'b1);
        step();
        in_data = 32'h2;
        check("same_pend_a", 32'(rd_pending0), 32'd1);
        step();
        check("same_pend_b", 32'(rd_pending0), 32'd1);
        check("same_rd_b",   rd_data0, 32'h1);
        in_data = 32'h3;
        step();
        in_valid = 1'b0;
        check("same_pend_c",  32'(rd_pending0), 32'd1);
        check("same_rd_c",    rd_data0, 32'h2);
        check("same_count_c", 32'(count), 32'd1);
        step();
        check("same_pend_d",  32'(rd_pending0), 32'd0);
        check("same_rd_d",    rd_data0, 32'h3);
        check("same_count_d", 32'(count), 32'd0);

        // Steady push+pop at count=2 across several pointer wraps
        wr_stall = 1'b1;
        for (int j = 0; j < 2; j++) begin
            offer(5'(16 + j), 32'h100 + 32'(j), 1'b1);
            step();
        end
        wr_stall = 1'b0;
        for (int k = 0; k < 20; k++) begin
            offer(5'(16 + ((k + 2) % 8)), 32'h100 + 32'(k + 2), 1'b1);
            peek(5'(16 + (k % 8)), 5'd0);
            step();
            check("steady_count", 32'(count), 32'd2);
            check("steady_rd",    rd_data0, 32'h100 + 32'(k));
        end
        in_valid = 1'b0;
        peek(5'd20, 5'd21);
        step(); step();
        check("steady_tail_rd0", rd_data0, 32'h114);
        check("steady_tail_rd1", rd_data1, 32'h115);
        check("steady_empty",    32'(count), 32'd0);

        // Reset with three queued entries and a concurrent offer
        wr_stall = 1'b1;
        for (int j = 0; j < 3; j++) begin
            offer(5'(1 + j), 32'h55 + 32'(j) * 32'h11, 1'b1);
            step();
        end
        check("prerst_count", 32'(count), 32'd3);
        offer(5'd9, 32'h99, 1'b1);
        wr_stall = 1'b0;
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        peek(5'd5, 5'd7);
        check("rst_count",  32'(count), 32'd0);
        check("rst_ready",  32'(in_ready), 32'd1);
        check("rst_reg5",   rd_data0, 32'h0);
        check("rst_reg7",   rd_data1, 32'h0);
        peek(5'd1, 5'd9);
        check("rst_pend1",  32'(rd_pending0), 32'd0);
        check("rst_pend9",  32'(rd_pending1), 32'd0);
        step(); step(); step();
        check("post_rst_reg1", rd_data0, 32'h0);
        check("post_rst_reg9", rd_data1, 32'h0);
        peek(5'd2, 5'd3);
        check("post_rst_reg2", rd_data0, 32'h0);
        check("post_rst_reg3", rd_data1, 32'h0);
        peek(5'd16, 5'd10);
        check("post_rst_reg16", rd_data0, 32'h0);
        check("post_rst_reg10", rd_data1, 32'h0);
        check("post_rst_count", 32'(count), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
